key_autorepeat: RTL and testbench
=================================

Name: key_autorepeat

Overview:
- Sits directly downstream of the button noise filter in the text-overlay control path.
- Takes the filtered, clean button level and turns it into discrete events:
  - a single-cycle press pulse;
  - a single-cycle release pulse;
  - "step" pulses for cursor/character stepping: one on press, then auto-repeat after a hold delay while the button stays down.
- The overlay character/cursor logic consumes `step` directly.

Parameters:
- HOLD_CYCLES, 25000000, cycles from the press step to the first repeat step (0.5 s at 50 MHz); must be >= 2.
- REPEAT_CYCLES, 5000000, cycles between consecutive repeat steps (0.1 s at 50 MHz); must be >= 2.
- CNT_W, 25, width of the internal delay counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  filtered button level from the noise filter; already synchronous to clk.
- en  input  1  auto-repeat enable; 0 suppresses repeat steps but not press/release.
- press_pulse  output  1  one-cycle pulse on button press.
- release_pulse  output  1  one-cycle pulse on button release.
- step  output  1  one-cycle pulse: on press and on each auto-repeat.
- held  output  1  level, high while in REPEAT state.
- repeat_cnt  output  8  repeat steps in the current hold; saturates at 255.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, btn_q=0;
  - press_pulse, release_pulse, step, held = 0; repeat_cnt=0.
  - Reset asserted mid-hold drops all outputs immediately; no release_pulse is generated.
- btn_q is btn delayed one clock.
  - Rising condition: btn=1 and btn_q=0.
  - Falling condition: btn=0 while state != IDLE.
  - A btn held high through reset produces a press on the first edge after rst_n deasserts.
- Default every edge: press_pulse, release_pulse, step <= 0 unless set below.
- States: IDLE, WAIT, REPEAT.
- IDLE:
  - On rising condition at edge k: press_pulse<=1, step<=1, counter<=0, repeat_cnt<=0, state<=WAIT.
  - Otherwise hold.
- WAIT (btn=1):
  - If counter==HOLD_CYCLES-1 and en=1: step<=1, counter<=0, repeat_cnt<=repeat_cnt+1, held<=1, state<=REPEAT.
  - If counter==HOLD_CYCLES-1 and en=0: counter holds at HOLD_CYCLES-1 and the state stays WAIT. The first repeat fires on the first edge en is sampled 1.
  - Otherwise counter<=counter+1.
- REPEAT (btn=1):
  - en=0: counter<=0, no step, held stays 1.
  - en=1 and counter==REPEAT_CYCLES-1: step<=1, counter<=0, repeat_cnt<=repeat_cnt+1 (saturating at 255).
  - en=1 otherwise: counter<=counter+1.
- WAIT or REPEAT with btn=0: release_pulse<=1, held<=0, counter<=0, state<=IDLE.
  - repeat_cnt keeps its value until the next press clears it.
- Simultaneous events: if release occurs on the edge the counter hits terminal, release wins; no step is issued.
- Timing (en=1, press detected at edge k):
  - steps at edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, k+HOLD_CYCLES+2*REPEAT_CYCLES, ...
  - held rises at edge k+HOLD_CYCLES.
- Latency:
  - press_pulse/step are high in the cycle after the first clk edge that samples btn=1.
  - release_pulse is high in the cycle after the first clk edge that samples btn=0.
- A release followed by a press on the very next cycle is a legal new press.
  - btn_q=0 at that edge, so press_pulse fires.
  - The minimum IDLE dwell is one cycle.
- Pulses never stretch beyond one cycle. step and release_pulse are never high in the same cycle.

Test Plan:
- Bench uses HOLD_CYCLES=8, REPEAT_CYCLES=3, CNT_W=4 for all scenarios.
- Reset then btn=0 for 10 cycles -> all outputs 0, repeat_cnt=0.
- Short press: btn=1 for 5 cycles, en=1 -> press_pulse=1 and step=1 for exactly one cycle each; held stays 0; release_pulse one cycle after btn falls; repeat_cnt=0.
- Long press: btn=1 for 20 cycles, en=1, press at edge k -> steps at k, k+8, k+11, k+14, k+17; held=1 from k+8; repeat_cnt=4 at release; single release_pulse.
- en=0 during hold: btn=1, en=0 for 15 cycles, then en=1 -> only the press step while en=0; first repeat step on the first edge en=1 is sampled; held rises on that edge.
- Collision: btn falls exactly at edge k+11 (terminal repeat edge) -> release_pulse=1, no step at k+11, state IDLE.
- Reset mid-REPEAT: assert rst_n=0 at k+12 -> held, step, repeat_cnt drop to 0 asynchronously; no release_pulse.
- Reset with btn=1: after rst_n rises -> press_pulse on the first edge after rst_n rises.

Source files
------------

// File: rtl/key_autorepeat.sv
// ============================================================================
// Module   : key_autorepeat
// Brief    : Turns a clean button level into press/release pulses and
//            step pulses with hold-delayed auto-repeat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_autorepeat #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       step,
    output logic       held,
    output logic [7:0] repeat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_q;
    logic             r_press;
    logic             r_release;
    logic             r_step;
    logic             r_held;
    logic [7:0]       r_repeat_cnt;
    logic [7:0]       w_repeat_inc;

    assign w_repeat_inc = (r_repeat_cnt == 8'hFF) ? r_repeat_cnt : r_repeat_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_btn_q      <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_step       <= 1'b0;
            r_held       <= 1'b0;
            r_repeat_cnt <= 8'd0;
        end else begin
            r_btn_q   <= btn;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_step    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (btn && !r_btn_q) begin
                        r_press      <= 1'b1;
                        r_step       <= 1'b1;
                        r_cnt        <= '0;
                        r_repeat_cnt <= 8'd0;
                        r_state      <= S_WAIT;
                    end
                end

                // Release is checked first so it wins over a terminal count.
                S_WAIT: begin
                    if (!btn) begin
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        if (en) begin
                            r_step       <= 1'b1;
                            r_cnt        <= '0;
                            r_repeat_cnt <= w_repeat_inc;
                            r_held       <= 1'b1;
                            r_state      <= S_REPEAT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_REPEAT: begin
                    if (!btn) begin
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else if (!en) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_REP_LAST) begin
                        r_step       <= 1'b1;
                        r_cnt        <= '0;
                        r_repeat_cnt <= w_repeat_inc;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign step          = r_step;
    assign held          = r_held;
    assign repeat_cnt    = r_repeat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_key_autorepeat.sv
// ============================================================================
// Module   : tb_key_autorepeat
// Brief    : Directed self-checking bench for key_autorepeat (HOLD=8, REP=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_key_autorepeat;

    localparam int HOLD_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 3;
    localparam int CNT_W         = 4;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       en;
    logic       press_pulse;
    logic       release_pulse;
    logic       step;
    logic       held;
    logic [7:0] repeat_cnt;

    int checks = 0;
    int errors = 0;

    key_autorepeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn          (btn),
        .en           (en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .step         (step),
        .held         (held),
        .repeat_cnt   (repeat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed order: press, release, step, held, repeat_cnt.
    task automatic chk(input string tag, input logic p, input logic r,
                       input logic s, input logic h, input logic [7:0] c);
        logic [11:0] obs;
        logic [11:0] exp_v;
        obs   = {press_pulse, release_pulse, step, held, repeat_cnt};
        exp_v = {p, r, s, h, c};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed p/r/s/h/cnt=%b expected %b", tag, obs, exp_v);
        end
    endtask

    // Expected outputs i edges after the press edge with en held at 1.
    function automatic logic exp_step(input int i);
        return (i == 0) || (i >= HOLD_CYCLES && (i - HOLD_CYCLES) % REPEAT_CYCLES == 0);
    endfunction

    function automatic logic [7:0] exp_cnt(input int i);
        return (i < HOLD_CYCLES) ? 8'd0 : 8'((i - HOLD_CYCLES) / REPEAT_CYCLES + 1);
    endfunction

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        en    = 1'b1;

        // Reset, then idle
        tick();
        tick();
        chk("reset", 0, 0, 0, 0, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle[%0d]", i), 0, 0, 0, 0, 8'd0);
        end

        // Short press: 5 cycles high
        btn = 1'b1;
        tick();
        chk("short_press", 1, 0, 1, 0, 8'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("short_hold[%0d]", i), 0, 0, 0, 0, 8'd0);
        end
        btn = 1'b0;
        tick();
        chk("short_release", 0, 1, 0, 0, 8'd0);
        tick();
        chk("short_after", 0, 0, 0, 0, 8'd0);
        tick();

        // Long press: 20 cycles high; release edge k+20 is also a terminal edge
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("long[%0d]", i), (i == 0), 0, exp_step(i),
                (i >= HOLD_CYCLES), exp_cnt(i));
        end
        btn = 1'b0;
        tick();
        chk("long_release", 0, 1, 0, 0, 8'd4);
        tick();
        chk("long_after", 0, 0, 0, 0, 8'd4);
        tick();

        // en=0 during hold: repeat deferred until en is sampled high
        en  = 1'b0;
        btn = 1'b1;
        tick();
        chk("en0_press", 1, 0, 1, 0, 8'd0);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk($sformatf("en0_hold[%0d]", i), 0, 0, 0, 0, 8'd0);
        end
        en = 1'b1;
        tick();
        chk("en1_first_repeat", 0, 0, 1, 1, 8'd1);
        tick();
        chk("en1_k16", 0, 0, 0, 1, 8'd1);
        tick();
        chk("en1_k17", 0, 0, 0, 1, 8'd1);
        tick();
        chk("en1_k18", 0, 0, 1, 1, 8'd2);
        btn = 1'b0;
        tick();
        chk("en1_release", 0, 1, 0, 0, 8'd2);
        tick();

        // Collision: btn low sampled at k+11 (terminal repeat edge)
        btn = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk($sformatf("coll[%0d]", i), (i == 0), 0, exp_step(i),
                (i >= HOLD_CYCLES), exp_cnt(i));
        end
        btn = 1'b0;
        tick();
        chk("coll_release", 0, 1, 0, 0, 8'd1);
        tick();
        chk("coll_idle", 0, 0, 0, 0, 8'd1);

        // Reset mid-REPEAT at k+12, btn held high through reset
        btn = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            tick();
            chk($sformatf("rst_pre[%0d]", i), (i == 0), 0, exp_step(i),
                (i >= HOLD_CYCLES), exp_cnt(i));
        end
        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, 0, 0, 0, 8'd0);
        tick();
        chk("rst_hold0", 0, 0, 0, 0, 8'd0);
        tick();
        chk("rst_hold1", 0, 0, 0, 0, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_btn_press", 1, 0, 1, 0, 8'd0);
        tick();
        chk("rst_btn_after", 0, 0, 0, 0, 8'd0);

        // Release then press on the very next cycle
        btn = 1'b0;
        tick();
        chk("quick_release", 0, 1, 0, 0, 8'd0);
        btn = 1'b1;
        tick();
        chk("quick_repress", 1, 0, 1, 0, 8'd0);
        btn = 1'b0;
        tick();
        chk("quick_release2", 0, 1, 0, 0, 8'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
